// File: rtl/serial_greater_than_if.sv
// Bundle of signals between serial_greater_than, its client, and the external
// 2-bit slice comparator.
interface serial_greater_than_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   slice_a;
    logic [1:0]   slice_b;
    logic         slice_gt;
    logic         busy;
    logic         done;
    logic         gt;
    logic         lt;
    logic         eq;

    modport master (
        output start, a, b, slice_gt,
        input  slice_a, slice_b, busy, done, gt, lt, eq
    );

    modport slave (
        input  start, a, b, slice_gt,
        output slice_a, slice_b, busy, done, gt, lt, eq
    );
endinterface

// File: rtl/serial_greater_than.sv
// Sequential unsigned magnitude comparator: resolves two W-bit operands two bits
// per clock, MSB first, using an external combinational 2-bit gt slice.
module serial_greater_than #(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_greater_than_if.slave  bus
);
    localparam int N  = W / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [W-1:0]   ra_r, rb_r, ra_nxt_s, rb_nxt_s;
    logic [CW-1:0]  cnt_r, cnt_nxt_s;
    logic           decided_r, wgt_r, wlt_r;
    logic           decided_nxt_s, wgt_nxt_s, wlt_nxt_s;
    logic           gt_r, lt_r, eq_r, gt_nxt_s, lt_nxt_s, eq_nxt_s;
    logic           busy_r, done_r;
    logic [1:0]     slice_a_s, slice_b_s;
    logic           seq_s;

    assign slice_a_s = ra_r[W-1 -: 2];
    assign slice_b_s = rb_r[W-1 -: 2];
    assign seq_s     = (slice_a_s == slice_b_s);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; the last RUN cycle is the one that sees cnt_r == 0
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath next values; results are published on the edge entering DONE
    // so they are already valid while done is high
    always_comb begin
        ra_nxt_s      = ra_r;
        rb_nxt_s      = rb_r;
        cnt_nxt_s     = cnt_r;
        decided_nxt_s = decided_r;
        wgt_nxt_s     = wgt_r;
        wlt_nxt_s     = wlt_r;
        gt_nxt_s      = gt_r;
        lt_nxt_s      = lt_r;
        eq_nxt_s      = eq_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    ra_nxt_s      = bus.a;
                    rb_nxt_s      = bus.b;
                    cnt_nxt_s     = CW'(N - 1);
                    decided_nxt_s = 1'b0;
                    wgt_nxt_s     = 1'b0;
                    wlt_nxt_s     = 1'b0;
                end else begin
                    ra_nxt_s = ra_r;
                end
            end
            RUN: begin
                if (!decided_r && bus.slice_gt) begin
                    wgt_nxt_s     = 1'b1;
                    decided_nxt_s = 1'b1;
                end else if (!decided_r && !seq_s) begin
                    wlt_nxt_s     = 1'b1;
                    decided_nxt_s = 1'b1;
                end else begin
                    decided_nxt_s = decided_r;
                end
                ra_nxt_s  = ra_r << 2;
                rb_nxt_s  = rb_r << 2;
                cnt_nxt_s = cnt_r - CW'(1);
                if (cnt_r == {CW{1'b0}}) begin
                    cnt_nxt_s = {CW{1'b0}};
                    gt_nxt_s  = wgt_nxt_s;
                    lt_nxt_s  = wlt_nxt_s;
                    eq_nxt_s  = ~(wgt_nxt_s | wlt_nxt_s);
                end else begin
                    gt_nxt_s  = gt_r;
                end
            end
            DONE:    ra_nxt_s = ra_r;
            default: ra_nxt_s = ra_r;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ra_r      <= {W{1'b0}};
            rb_r      <= {W{1'b0}};
            cnt_r     <= {CW{1'b0}};
            decided_r <= 1'b0;
            wgt_r     <= 1'b0;
            wlt_r     <= 1'b0;
            gt_r      <= 1'b0;
            lt_r      <= 1'b0;
            eq_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            ra_r      <= ra_nxt_s;
            rb_r      <= rb_nxt_s;
            cnt_r     <= cnt_nxt_s;
            decided_r <= decided_nxt_s;
            wgt_r     <= wgt_nxt_s;
            wlt_r     <= wlt_nxt_s;
            gt_r      <= gt_nxt_s;
            lt_r      <= lt_nxt_s;
            eq_r      <= eq_nxt_s;
            busy_r    <= (state_nxt_s == RUN);
            done_r    <= (state_nxt_s == DONE);
        end
    end

    assign bus.slice_a = slice_a_s;
    assign bus.slice_b = slice_b_s;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.gt      = gt_r;
    assign bus.lt      = lt_r;
    assign bus.eq      = eq_r;
endmodule

// File: doc/serial_greater_than.md
# serial_greater_than

Sequential W-bit magnitude comparator that resolves two unsigned operands two bits per clock, MSB first. It sits directly upstream of the combinational 2-bit greater-than slice. Each cycle it drives one 2-bit operand pair into that slice, consumes the slice's `gt` output in the same cycle, and computes slice equality internally. A start/busy/done handshake wraps the whole comparison.

## Interface

Parameters:
- `W`, default 8. Operand width in bits. Must be even and ≥ 2. Number of slices is N = W/2.

Ports:
- `clk`, in, 1. Single system clock; all state updates on the rising edge.
- `reset`, in, 1. Synchronous, active-high reset.
- `start`, in, 1. Request a comparison. Sampled only in IDLE.
- `a`, in, W. Operand A (unsigned). Latched on an accepted start.
- `b`, in, W. Operand B (unsigned). Latched on an accepted start.
- `slice_a`, out, 2. Current 2-bit slice of A, to the slice comparator's `a`.
- `slice_b`, out, 2. Current 2-bit slice of B, to the slice comparator's `b`.
- `slice_gt`, in, 1. Combinational `gt` returned from the slice comparator. Sampled in the same cycle.
- `busy`, out, 1. High while in RUN.
- `done`, out, 1. One-cycle pulse when the result registers are updated.
- `gt`, out, 1. Registered result: a > b.
- `lt`, out, 1. Registered result: a < b.
- `eq`, out, 1. Registered result: a == b.

## Operation

FSM states: IDLE, RUN, DONE.

- **IDLE**
  - On `start`=1: load `a`, `b` into shift registers `ra`, `rb`.
  - Load slice counter with N−1.
  - Clear working flags `decided` = 0, `wgt` = 0, `wlt` = 0.
  - Go to RUN.
- **RUN**
  - `slice_a` = `ra[W-1:W-2]`, `slice_b` = `rb[W-1:W-2]`.
  - Slice equality `seq` = (`slice_a` == `slice_b`).
  - If `decided` = 0 and `slice_gt` = 1: set `wgt` = 1, `decided` = 1.
  - Else if `decided` = 0 and `seq` = 0: set `wlt` = 1, `decided` = 1.
  - Once `decided` = 1, later slices are ignored.
  - Each cycle shift `ra`, `rb` left by 2 (zero fill) and decrement the counter.
  - When the counter = 0 at the edge, go to DONE; the final slice's decision is included.
- **DONE** (exactly one cycle)
  - `gt` ← `wgt`, `lt` ← `wlt`, `eq` ← ~(`wgt` | `wlt`).
  - `done` = 1.
  - Go to IDLE. `start` is ignored in this cycle.

Rules:
- No early termination: latency is fixed regardless of operand values.
- Exactly one of `gt`/`lt`/`eq` is high after any completed comparison.
- `gt`/`lt`/`eq` hold their last values until the next DONE.
- `start` while in RUN or DONE is ignored; it is neither queued nor does it alter the operands.
- Operand inputs `a`/`b` are don't-care except in the accepting cycle.

## Timing

- Reset values:
  - state = IDLE
  - `ra` = `rb` = 0, so `slice_a` = `slice_b` = 0
  - `busy` = 0, `done` = 0, `gt` = 0, `lt` = 0, `eq` = 0
  - counter = 0, working flags = 0
- `start` sampled at edge k → RUN during cycles k+1 … k+N. `busy` = 1 exactly for those N cycles.
- `done` = 1 in cycle k+N+1. `gt`/`lt`/`eq` are valid from that cycle onward.
- Earliest next accepted `start` is the edge ending cycle k+N+2 (first IDLE cycle). Start-to-start throughput is N+2 cycles.
- `slice_a`/`slice_b` are registered outputs. `slice_gt` is expected to be purely combinational from them within the same cycle; no registered feedback path is assumed.
- `reset` asserted in any state:
  - Next cycle is IDLE with all reset values.
  - The pending comparison is abandoned.
  - No `done` pulse is generated.
  - Previous results are cleared.
- `reset` and `start` high together: reset wins.

## Test plan

- **Reset values:** W=8. Hold `reset` 2 cycles → all outputs 0 and state IDLE. Then `start` with a=0xA5, b=0xA4.
  - Required: `busy` high 4 cycles.
  - Slice pairs (2,2),(2,2),(1,1),(1,0).
  - `done` pulses in cycle 5 after start, with gt=1, lt=0, eq=0.
- **MSB decides:** a=0x3C, b=0xC3 → first slice pair (0,3) decides lt=1. gt=0, eq=0 at `done`, latency still 5 cycles.
- **Equal operands:** a=b=0x5A → eq=1, gt=0, lt=0. Extremes a=0x00/b=0xFF → lt=1; a=0xFF/b=0x00 → gt=1.
- **Start ignored while busy:** pulse `start` with new operands in the 2nd RUN cycle and again in the DONE cycle.
  - Required: exactly one `done` for the original comparison, with its original result.
  - No second comparison starts.
- **Reset mid-operation:** `reset` in the 3rd RUN cycle → next cycle IDLE, `busy` = 0, no `done` pulse, gt/lt/eq = 0. A following start completes normally.
- **Back-to-back:** `start` held continuously with 0x80 vs 0x7F then 0x01 vs 0x02.
  - Required: results gt=1 then lt=1.
  - `done` pulses 6 cycles apart.
  - Prior result held between pulses.
